// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator result/display path.
//   CALC_RES_W       - width of the calculator RESULT word
//   BCD_DIGIT_W      - bits per packed BCD digit
//   calc_bcd_state_t - state encoding of the binary-to-BCD converter
package calc_pkg;

  localparam int CALC_RES_W  = 8;
  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } calc_bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one digit of the double-dabble add-3 correction.
//   din  - BCD digit before the shift
//   dout - din + 3 when din >= 5, otherwise din unchanged
// Digits never exceed 9 before adjustment, so the result fits in 4 bits.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_DIGIT_W'(5)) ? din + BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/calc_result_bcd.sv
// calc_result_bcd: sequential binary-to-BCD converter (one bit per clock).
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake; in_data is the unsigned RESULT
//   out_valid/out_ready - output handshake; out_bcd/out_lz held until taken
//   out_bcd             - packed BCD, digit 0 (ones) in bits [3:0]
//   out_lz              - bit k set when digit k is a leading zero
//   busy                - high while the shift engine is running
module calc_result_bcd
  import calc_pkg::*;
#(
  parameter int IN_W   = CALC_RES_W,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]             out_lz,
  output logic                          busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  calc_bcd_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  shreg_q, shreg_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic [DIGITS-1:0] out_lz_q, out_lz_d;
  logic out_valid_q, out_valid_d;
  logic in_ready_q, in_ready_d;
  logic busy_q, busy_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic [DIGITS-1:0] lz_next;

  // Add-3 correction on every digit in parallel, from pre-shift values.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (bcd_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // {bcd, shreg} shifted left by one; shreg MSB enters the ones digit.
  assign bcd_shift = {bcd_adj[BCD_W-2:0], shreg_q[IN_W-1]};

  // Digit k is blank when it and every digit above it are zero.
  // The ones digit is always shown so that zero displays as "0".
  assign lz_next[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign lz_next[gi] = (bcd_shift[BCD_W-1 : gi*BCD_DIGIT_W] == '0);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    bcd_d       = bcd_q;
    out_bcd_d   = out_bcd_q;
    out_lz_d    = out_lz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d    = in_data;
          bcd_d      = '0;
          cnt_d      = CNT_LOAD;
          state_d    = SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        bcd_d   = bcd_shift;
        shreg_d = {shreg_q[IN_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Last bit: publish the finished value straight from the shifter.
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          out_bcd_d   = bcd_shift;
          out_lz_d    = lz_next;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_bcd_d   = '0;
          out_lz_d    = '0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_bcd_d   = '0;
        out_lz_d    = '0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      bcd_q       <= '0;
      out_bcd_q   <= '0;
      out_lz_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      bcd_q       <= bcd_d;
      out_bcd_q   <= out_bcd_d;
      out_lz_q    <= out_lz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign out_bcd   = out_bcd_q;
  assign out_lz    = out_lz_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_result_bcd.sv
// tb_calc_result_bcd: scoreboard bench for calc_result_bcd.
//   Stimulus pushes hand-computed BCD/leading-zero expectations into a queue;
//   a negedge monitor pops and compares on every output transfer.
module tb_calc_result_bcd;

  localparam int IN_W   = 8;
  localparam int DIGITS = 3;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  lz;
    int          val;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic [2:0]  out_lz;
  logic        busy;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   accept_cyc;
  int   prev_accept;
  logic ov_prev;

  calc_result_bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_lz    (out_lz),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: latency on each out_valid rise, data on each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev)
        check("latency", 32'(cyc - accept_cyc), 32'(IN_W));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got bcd 0x%0h, expected no output", out_bcd);
        end else begin
          e = exp_q.pop_front();
          $display("xfer value %0d: bcd=0x%03h lz=%b", e.val, out_bcd, out_lz);
          check($sformatf("bcd_%0d", e.val), 32'(out_bcd), 32'(e.bcd));
          check($sformatf("lz_%0d", e.val), 32'(out_lz), 32'(e.lz));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a value; returns after the accepting edge. keep leaves in_valid high.
  task automatic send(input int v, input logic [11:0] eb, input logic [2:0] el,
                      input bit expect_out, input bit keep);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_data  = 8'(v);
    if (expect_out) begin
      e.bcd = eb; e.lz = el; e.val = v;
      exp_q.push_back(e);
    end
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: value %0d never accepted", v);
    end
    tick();
    prev_accept = accept_cyc;
    accept_cyc  = cyc;
    $display("accept value %0d at cycle %0d", v, accept_cyc);
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait (bounded) until out_valid is seen high after an edge.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid 0, expected 1", name);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    accept_cyc = 0;
    prev_accept = 0;
    ov_prev = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    check("rst_out_lz", 32'(out_lz), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Zero: only the ones digit is shown.
    send(0, 12'h000, 3'b110, 1'b1, 1'b0);
    check("busy_shift", 32'(busy), 32'd1);
    wait_valid("v0");
    tick();

    // 225: single-cycle DONE, then back to IDLE.
    send(225, 12'h225, 3'b000, 1'b1, 1'b0);
    wait_valid("v225");
    tick();
    check("idle_after_225", 32'({out_valid, in_ready, busy}), 32'b010);

    // 30 and 255 back to back with in_valid held throughout.
    send(30, 12'h030, 3'b100, 1'b1, 1'b1);
    send(255, 12'h255, 3'b000, 1'b1, 1'b0);
    check("b2b_spacing", 32'(accept_cyc - prev_accept), 32'(IN_W + 2));
    wait_valid("v255");
    tick();

    // 7 under backpressure: output frozen for 20 cycles.
    out_ready = 1'b0;
    send(7, 12'h007, 3'b110, 1'b1, 1'b0);
    wait_valid("v7");
    for (int i = 0; i < 20; i++) begin
      check("hold_bcd", 32'(out_bcd), 32'h007);
      check("hold_flags", 32'({out_valid, in_ready, busy, out_lz}), 32'b100_110);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("release_idle", 32'({out_valid, in_ready, out_bcd}), 32'({1'b0, 1'b1, 12'h000}));

    // 99 aborted by reset in the fourth SHIFT cycle; no output expected.
    send(99, 12'h099, 3'b100, 1'b0, 1'b0);
    repeat (3) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_flags", 32'({out_valid, busy, in_ready}), 32'b001);
    tick();
    rst = 1'b0;
    tick();
    send(12, 12'h012, 3'b100, 1'b1, 1'b0);
    wait_valid("v12");
    tick();

    // 128 with in_data/in_valid wiggled during SHIFT.
    send(128, 12'h128, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_data  = 8'(8'd99 + 8'(i * 37));
      in_valid = ~in_valid;
      tick();
    end
    in_valid = 1'b0;
    wait_valid("v128");
    repeat (3) tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
